md5_chunk_feeder: RTL and testbench

Front end of the MD5 engine. Accepts a message as a stream of little-endian 32-bit words and applies MD5 padding: a 0x80 byte, zero fill, and a 64-bit bit-length. It assembles each 512-bit chunk in a 16x32 buffer, serves that buffer to the chunk cruncher's word-read port (gaddr/mdata), pulses the cruncher's start, and waits for its done before refilling.

---
 rtl/md5_chunk_feeder.sv | 184 ++++++++++++++++++
 tb/tb_md5_chunk_feeder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_chunk_feeder.sv
// MD5 front end: packs little-endian message words into 512-bit chunks,
// applies MD5 padding and length, and hands each chunk to the cruncher.
module md5_chunk_feeder #(
    parameter int LEN_W = 61
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        crunch_clear,
    output logic        crunch_start,
    input  logic        crunch_done,
    input  logic [3:0]  gaddr,
    output logic [31:0] mdata,
    output logic        msg_done
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_LEN,
        S_CRUNCH,
        S_WAIT0,
        S_WAIT
    } state_t;

    state_t             state, state_n;
    state_t             ret, ret_n;
    logic [3:0]         wptr, wptr_n;
    logic [LEN_W-1:0]   byte_cnt, cnt_n;
    logic               pad_pending, pad_n;
    logic               fin, fin_n;
    logic               first, first_n;

    logic [31:0]        mem [16];
    logic               we;
    logic               len_we;
    logic [31:0]        wdata;
    logic [31:0]        lword;
    logic [2:0]         n_eff;
    logic [63:0]        bitlen;
    logic               xfer;

    assign in_ready = (state == S_FILL) && reset_n;
    assign xfer     = in_valid && in_ready;
    assign mdata    = mem[gaddr];
    assign n_eff    = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign bitlen   = 64'({byte_cnt, 3'b000});

    // Final word: keep the valid bytes, drop the 0x80 marker right after them.
    always_comb begin
        lword = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n_eff)
                lword[8*k +: 8] = in_data[8*k +: 8];
            else if (3'(k) == n_eff)
                lword[8*k +: 8] = 8'h80;
        end
    end

    // Next-state, buffer write controls and handshake pulses.
    always_comb begin
        state_n      = state;
        ret_n        = ret;
        wptr_n       = wptr;
        cnt_n        = byte_cnt;
        pad_n        = pad_pending;
        fin_n        = fin;
        first_n      = first;
        we           = 1'b0;
        len_we       = 1'b0;
        wdata        = in_data;
        crunch_clear = 1'b0;
        crunch_start = 1'b0;
        msg_done     = 1'b0;
        unique case (state)
            S_FILL: begin
                if (xfer) begin
                    if (first) begin
                        crunch_clear = 1'b1;
                        first_n      = 1'b0;
                    end
                    we     = 1'b1;
                    wptr_n = wptr + 4'd1;
                    if (!in_last) begin
                        cnt_n = byte_cnt + LEN_W'(4);
                        if (wptr == 4'd15) begin
                            ret_n   = S_FILL;
                            state_n = S_CRUNCH;
                        end
                    end else begin
                        wdata = lword;
                        cnt_n = byte_cnt + LEN_W'(n_eff);
                        pad_n = (n_eff == 3'd4);
                        if (wptr == 4'd15) begin
                            ret_n   = S_PAD;
                            state_n = S_CRUNCH;
                        end else begin
                            state_n = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                if (wptr == 4'd14 && !pad_pending) begin
                    state_n = S_LEN;
                end else begin
                    we     = 1'b1;
                    wdata  = pad_pending ? 32'h00000080 : 32'h0;
                    pad_n  = 1'b0;
                    wptr_n = wptr + 4'd1;
                    if (wptr == 4'd15) begin
                        ret_n   = S_PAD;
                        state_n = S_CRUNCH;
                    end
                end
            end
            S_LEN: begin
                len_we  = 1'b1;
                fin_n   = 1'b1;
                state_n = S_CRUNCH;
            end
            S_CRUNCH: begin
                crunch_start = 1'b1;
                state_n      = S_WAIT0;
            end
            S_WAIT0: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (crunch_done) begin
                    wptr_n = 4'd0;
                    if (fin) begin
                        msg_done = 1'b1;
                        cnt_n    = '0;
                        fin_n    = 1'b0;
                        first_n  = 1'b1;
                        state_n  = S_FILL;
                    end else begin
                        state_n = ret;
                    end
                end
            end
            default: begin
                state_n = S_FILL;
            end
        endcase
    end

    // Control state, abandoned on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FILL;
            ret         <= S_FILL;
            wptr        <= 4'd0;
            byte_cnt    <= '0;
            pad_pending <= 1'b0;
            fin         <= 1'b0;
            first       <= 1'b1;
        end else begin
            state       <= state_n;
            ret         <= ret_n;
            wptr        <= wptr_n;
            byte_cnt    <= cnt_n;
            pad_pending <= pad_n;
            fin         <= fin_n;
            first       <= first_n;
        end
    end

    // Chunk buffer; the length words land together in one cycle.
    always_ff @(posedge clk) begin
        if (we)
            mem[wptr] <= wdata;
        if (len_we) begin
            mem[14] <= bitlen[31:0];
            mem[15] <= bitlen[63:32];
        end
    end

endmodule

// File: tb/tb_md5_chunk_feeder.sv
// Bench for md5_chunk_feeder: a behavioural MD5 cruncher reads each chunk
// and a scoreboard of expected digests is checked on every msg_done.
module tb_md5_chunk_feeder;

    typedef logic [31:0] blk_t [16];

    typedef struct {
        int           len;
        int           kind;
        bit           zlast;
        bit           n7;
        int           chunks;
        bit           has_kat;
        logic [127:0] kat;
    } vec_t;

    localparam logic [127:0] INIT = 128'h67452301_efcdab89_98badcfe_10325476;

    localparam logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        crunch_clear;
    logic        crunch_start;
    logic        crunch_done;
    logic [3:0]  gaddr;
    logic [31:0] mdata;
    logic        msg_done;

    md5_chunk_feeder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_nbytes    (in_nbytes),
        .crunch_clear (crunch_clear),
        .crunch_start (crunch_start),
        .crunch_done  (crunch_done),
        .gaddr        (gaddr),
        .mdata        (mdata),
        .msg_done     (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           ncmp = 0;
    int           nfail = 0;
    int           starts = 0;
    int           clears = 0;
    int           msgs = 0;
    int           viol = 0;
    int           collide = 0;
    int           cphase = 0;
    int           ridx = 0;
    int           cidx = 0;
    logic [127:0] dig;
    blk_t         mw;
    blk_t         clog [4];
    logic [127:0] sb [$];
    vec_t         tbl [10];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] fmt(input logic [127:0] st);
        return {bs(st[127:96]), bs(st[95:64]), bs(st[63:32]), bs(st[31:0])};
    endfunction

    function automatic int shamt(input int i);
        case (i / 16)
            0: case (i % 4) 0: return 7; 1: return 12; 2: return 17; default: return 22; endcase
            1: case (i % 4) 0: return 5; 1: return 9; 2: return 14; default: return 20; endcase
            2: case (i % 4) 0: return 4; 1: return 11; 2: return 16; default: return 23; endcase
            default: case (i % 4) 0: return 6; 1: return 10; 2: return 15; default: return 21; endcase
        endcase
    endfunction

    function automatic logic [127:0] md5c(input logic [127:0] st, input blk_t m);
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            s = shamt(i);
            t = f + a + K[i] + m[g];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    function automatic logic [7:0] mbyte(input int idx, input int kind);
        if (kind == 1) begin
            case (idx)
                0: return 8'h61;
                1: return 8'h62;
                default: return 8'h63;
            endcase
        end
        return 8'((idx * 37 + 11) & 255);
    endfunction

    function automatic logic [127:0] md5_sw(input int len, input int kind);
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [127:0] st;
        blk_t         m;
        for (int i = 0; i < len; i++) p.push_back(mbyte(i, kind));
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(len) << 3;
        for (int k = 0; k < 8; k++) p.push_back(bl[8*k +: 8]);
        st = INIT;
        for (int c = 0; c < p.size() / 64; c++) begin
            for (int w = 0; w < 16; w++)
                m[w] = {p[c*64+4*w+3], p[c*64+4*w+2], p[c*64+4*w+1], p[c*64+4*w]};
            st = md5c(st, m);
        end
        return fmt(st);
    endfunction

    // Behavioural cruncher: done drops one cycle after start, then 16 reads.
    initial begin
        crunch_done = 1'b1;
        gaddr = 4'd0;
        dig = INIT;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cphase = 0;
                crunch_done = 1'b1;
                gaddr = 4'd0;
            end else begin
                if (crunch_clear) dig = INIT;
                case (cphase)
                    0: if (crunch_start) cphase = 1;
                    1: begin
                        crunch_done = 1'b0;
                        gaddr = 4'd0;
                        ridx = 0;
                        cphase = 2;
                    end
                    default: begin
                        mw[ridx] = mdata;
                        ridx++;
                        if (ridx == 16) begin
                            if (cidx < 4) clog[cidx] = mw;
                            cidx++;
                            dig = md5c(dig, mw);
                            crunch_done = 1'b1;
                            cphase = 0;
                        end else begin
                            gaddr = 4'(ridx);
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pulse counts, ready while busy, digest scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (crunch_start) starts++;
            if (crunch_clear) clears++;
            if (crunch_clear && crunch_start) collide++;
            if (in_ready && (crunch_start || !crunch_done)) viol++;
            if (msg_done) begin
                msgs++;
                if (sb.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_msg_done: got 1 want 0");
                end else begin
                    chk("digest", fmt(dig), sb.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n);
        bit ok;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        in_nbytes = n;
        ok = 0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            ncmp++;
            nfail++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input int i);
        int s0, c0, m0, nfull, rem;
        logic [31:0] w;
        logic        lst;
        vec_t v;
        v = tbl[i];
        s0 = starts; c0 = clears; m0 = msgs; cidx = 0;
        sb.push_back(v.has_kat ? v.kat : md5_sw(v.len, v.kind));
        nfull = v.len / 4;
        rem = v.len % 4;
        for (int j = 0; j < nfull; j++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = mbyte(4 * j + b, v.kind);
            lst = (j == nfull - 1) && rem == 0 && !v.zlast;
            send(w, lst, lst ? (v.n7 ? 3'd7 : 3'd4) : 3'd2);
        end
        if (rem > 0) begin
            w = 32'hA5A5A5A5;
            for (int b = 0; b < rem; b++) w[8*b +: 8] = mbyte(4 * nfull + b, v.kind);
            send(w, 1'b1, 3'(rem));
        end else if (v.zlast || v.len == 0) begin
            send(32'hDEADBEEF, 1'b1, 3'd0);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int k = 0; k < 3000 && msgs == m0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #3;
        chk($sformatf("starts_%0d", i), 128'(starts - s0), 128'(v.chunks));
        chk($sformatf("clears_%0d", i), 128'(clears - c0), 128'd1);
        chk($sformatf("msg_done_%0d", i), 128'(msgs - m0), 128'd1);
        if (i == 0) begin
            chk("empty_w0", 128'(clog[0][0]), 128'h80);
            chk("empty_w15", 128'(clog[0][15]), 128'h0);
        end
        if (i == 1) begin
            chk("abc_w0", 128'(clog[0][0]), 128'h80636261);
            chk("abc_w14", 128'(clog[0][14]), 128'h18);
            chk("abc_w15", 128'(clog[0][15]), 128'h0);
        end
        if (i == 2) begin
            chk("b55_w13", 128'(clog[0][13][31:24]), 128'h80);
            chk("b55_w14", 128'(clog[0][14]), 128'h1B8);
        end
        if (i == 3) begin
            chk("b56_c1w14", 128'(clog[0][14]), 128'h80);
            chk("b56_c1w15", 128'(clog[0][15]), 128'h0);
            chk("b56_c2w0", 128'(clog[1][0]), 128'h0);
            chk("b56_c2w14", 128'(clog[1][14]), 128'h1C0);
        end
        if (i == 4) begin
            chk("b64_c2w0", 128'(clog[1][0]), 128'h80);
            chk("b64_c2w14", 128'(clog[1][14]), 128'h200);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        tbl[0] = '{0, 1, 1'b0, 1'b0, 1, 1'b1, 128'hd41d8cd98f00b204e9800998ecf8427e};
        tbl[1] = '{3, 1, 1'b0, 1'b0, 1, 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72};
        tbl[2] = '{55, 0, 1'b0, 1'b0, 1, 1'b0, 128'h0};
        tbl[3] = '{56, 0, 1'b0, 1'b0, 2, 1'b0, 128'h0};
        tbl[4] = '{64, 0, 1'b0, 1'b0, 2, 1'b0, 128'h0};
        tbl[5] = '{64, 0, 1'b1, 1'b0, 2, 1'b0, 128'h0};
        tbl[6] = '{60, 0, 1'b0, 1'b1, 2, 1'b0, 128'h0};
        tbl[7] = '{119, 0, 1'b0, 1'b0, 2, 1'b0, 128'h0};
        tbl[8] = '{120, 0, 1'b0, 1'b0, 3, 1'b0, 128'h0};
        tbl[9] = '{57, 0, 1'b0, 1'b0, 2, 1'b0, 128'h0};

        reset_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h0;
        in_last = 1'b0;
        in_nbytes = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_start", 128'(crunch_start), 128'd0);
        chk("rst_clear", 128'(crunch_clear), 128'd0);
        chk("rst_msg_done", 128'(msg_done), 128'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_msg(i);

        for (int j = 0; j < 16; j++) send(32'h01010101 * j, 1'b0, 3'd4);
        in_valid = 1'b0;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            #1;
            hit = (cphase == 2);
        end
        chk("mid_wait_reached", 128'(hit), 128'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_start", 128'(crunch_start), 128'd0);
        chk("mid_rst_msg_done", 128'(msg_done), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        run_msg(1);

        chk("ready_while_busy", 128'(viol), 128'd0);
        chk("clear_start_overlap", 128'(collide), 128'd0);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
